// File: rtl/trigger_capture.sv
// trigger_capture: logic-analyzer capture front end; delay-aligned samples fill a circular buffer until a trigger edge plus holdoff, then the buffer streams out oldest-first.
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   sample_in/sample_valid probed word and its qualifier
//   trigger, arm           raw trigger level, one-cycle capture request
//   data_in                delay-line output, i.e. the buffer write word
//   rd_data/rd_valid/rd_ready/rd_last  readout stream
//   state                  IDLE=0 ARMED=1 HOLDOFF=2 READOUT=3
//   capture_done           one-cycle pulse after the final word is accepted
module trigger_capture #(
  parameter int DATA_WIDTH      = 8,
  parameter int MEMORY_SIZE     = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int USER_HOLDOFF    = 4,
  parameter int ALIGNMENT_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  trigger,
  input  logic                  arm,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic [1:0]            state,
  output logic                  capture_done
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLDOFF = 2'd2, READOUT = 2'd3} state_t;
  localparam logic [ADDR_WIDTH:0]   L_FULL = (ADDR_WIDTH+1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0]   L_LAST = (ADDR_WIDTH+1)'(MEMORY_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   L_HOLD = (ADDR_WIDTH+1)'(USER_HOLDOFF);
  localparam logic [ADDR_WIDTH:0]   C_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] P_ONE  = ADDR_WIDTH'(1);
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_fill, r_hold, r_rd_cnt;
  logic                  r_trig_q, r_q_vld, r_q_last;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_mem [MEMORY_SIZE];
  logic w_trig_edge, w_trig_ok, w_wr_en, w_hold_done, w_enter_ro, w_out_rdy, w_issue, w_done;
  generate
    if (ALIGNMENT_DELAY == 0) begin : g_direct
      assign data_in = sample_in;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] r_dly [ALIGNMENT_DELAY];
      always_ff @(posedge clk or posedge reset)
        if (reset) for (int i = 0; i < ALIGNMENT_DELAY; i++) r_dly[i] <= '0;
        else if (sample_valid) begin
          r_dly[0] <= sample_in;
          for (int i = 1; i < ALIGNMENT_DELAY; i++) r_dly[i] <= r_dly[i-1];
        end
      assign data_in = r_dly[ALIGNMENT_DELAY-1];
    end
  endgenerate
  // trigger history advances per qualified sample so edges are judged sample-to-sample
  assign w_trig_edge = trigger & ~r_trig_q;
  assign w_wr_en     = sample_valid & (r_state == ARMED | r_state == HOLDOFF);
  assign w_trig_ok   = (r_state == ARMED) & sample_valid & w_trig_edge & (r_fill == L_FULL);
  assign w_hold_done = (r_state == HOLDOFF) & sample_valid & (r_hold + C_ONE == L_HOLD);
  assign w_enter_ro  = (w_trig_ok & (USER_HOLDOFF == 0)) | w_hold_done;
  // two-stage read pipe: r_q is the RAM output register, rd_* the output register;
  // a new read is issued whenever r_q is empty or is being drained this cycle
  assign w_out_rdy   = ~rd_valid | rd_ready;
  assign w_issue     = (r_state == READOUT) & (r_rd_cnt != L_FULL) & (~r_q_vld | w_out_rdy);
  assign w_done      = (r_state == READOUT) & rd_valid & rd_ready & rd_last;
  assign state       = r_state;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = arm ? ARMED : IDLE;
      ARMED:   w_next = w_trig_ok ? ((USER_HOLDOFF == 0) ? READOUT : HOLDOFF) : ARMED;
      HOLDOFF: w_next = w_hold_done ? READOUT : HOLDOFF;
      READOUT: w_next = w_done ? IDLE : READOUT;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_trig_q     <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_hold       <= '0;
      r_rd_cnt     <= '0;
      r_q_vld      <= 1'b0;
      r_q_last     <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      if (sample_valid) r_trig_q <= trigger;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (r_state == IDLE && arm) r_fill <= '0;
      else if (r_state == ARMED && sample_valid && r_fill != L_FULL) r_fill <= r_fill + C_ONE;
      if (w_trig_ok) r_hold <= '0;
      else if (r_state == HOLDOFF && sample_valid) r_hold <= r_hold + C_ONE;
      // the entering cycle also writes, so the oldest word sits one past the current write pointer
      if (w_enter_ro) begin
        r_rd_ptr <= r_wr_ptr + P_ONE;
        r_rd_cnt <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
        r_rd_cnt <= r_rd_cnt + C_ONE;
      end
      if (w_issue) r_q_last <= (r_rd_cnt == L_LAST);
      r_q_vld <= w_issue | (r_q_vld & ~w_out_rdy);
      if (w_out_rdy) begin
        rd_valid <= r_q_vld;
        rd_data  <= r_q;
        rd_last  <= r_q_vld & r_q_last;
      end
      capture_done <= w_done;
    end
  // buffer contents survive reset, so the RAM and its read register stay out of the reset domain
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= data_in;
    if (w_issue) r_q <= r_mem[r_rd_ptr];
  end
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed scoreboard bench for trigger_capture
module tb_trigger_capture;
  localparam int DW = 8, MS = 16, AW = 4, UH = 4, AD = 2;
  logic clk = 1'b0, reset = 1'b1, sample_valid = 1'b0, trigger = 1'b0, arm = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [DW-1:0] data_in, rd_data;
  logic rd_valid, rd_last, capture_done;
  logic [1:0] state;
  int checks = 0, failures = 0;
  int cnt, trig_at, early_at, ncyc, popped, since_rst;
  bit gap, bp, arm_ro, arm_now, fin, done_pend;
  logic [DW-1:0] qh[$];
  logic [DW-1:0] sb[$];
  always #5 clk = ~clk;
  trigger_capture #(.DATA_WIDTH(DW), .MEMORY_SIZE(MS), .ADDR_WIDTH(AW), .USER_HOLDOFF(UH), .ALIGNMENT_DELAY(AD)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid), .trigger(trigger), .arm(arm),
    .data_in(data_in), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .state(state), .capture_done(capture_done));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data_in"}, data_in, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_capture_done"}, capture_done, 0);
    chk({tag, "_state"}, state, 0);
  endtask
  task automatic cyc();
    logic v, r;
    @(negedge clk);
    v = gap ? (ncyc % 3 != 2) : 1'b1;
    r = bp ? (ncyc % 4 == 0 || ncyc % 4 == 3) : 1'b1;
    sample_valid = v;
    sample_in = cnt[DW-1:0];
    trigger = (cnt >= trig_at) || (cnt == early_at);
    arm = arm_now || (arm_ro && popped == 5);
    arm_now = 1'b0;
    rd_ready = r;
    if (since_rst >= AD) chk("data_in", data_in, qh[qh.size() - AD]);
    if (done_pend) begin
      chk("capture_done", capture_done, 1);
      chk("done_state", state, 0);
      chk("rd_valid_after", rd_valid, 0);
      done_pend = 1'b0;
      fin = 1'b1;
    end else chk("no_done", capture_done, 0);
    if (rd_valid && sb.size() == 0) chk("spurious_valid", rd_valid, 0);
    else if (rd_valid) begin
      chk("rd_data", rd_data, sb[0]);
      chk("rd_last", rd_last, sb.size() == 1);
      if (r) begin
        void'(sb.pop_front());
        popped++;
        done_pend = (sb.size() == 0);
      end
    end
    if (v) begin
      qh.push_back(cnt[DW-1:0]);
      since_rst++;
      if (cnt == trig_at + UH)
        for (int i = 0; i < MS; i++) sb.push_back(qh[qh.size() - 3 - (MS - 1) + i]);
      cnt++;
    end
    ncyc++;
  endtask
  task automatic start(input int t_at, input int e_at, input bit g, input bit b, input bit aro);
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    trigger = 1'b0;
    arm = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    qh.delete();
    sb.delete();
    cnt = 1;
    ncyc = 0;
    popped = 0;
    since_rst = 0;
    fin = 1'b0;
    done_pend = 1'b0;
    arm_now = 1'b1;
    trig_at = t_at;
    early_at = e_at;
    gap = g;
    bp = b;
    arm_ro = aro;
  endtask
  task automatic finish_capture(input string tag);
    int guard = 0;
    while (!fin && guard < 400) begin
      cyc();
      guard++;
    end
    checks++;
    assert (fin) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=1", tag, fin);
    end
    repeat (3) begin
      cyc();
      chk({tag, "_idle_hold"}, state, 0);
    end
  endtask
  initial begin
    trig_at = 1000;
    early_at = 0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    start(40, 0, 1'b0, 1'b0, 1'b0);
    finish_capture("basic");
    start(40, 10, 1'b0, 1'b0, 1'b0);
    finish_capture("early");
    start(40, 0, 1'b0, 1'b1, 1'b0);
    finish_capture("backpressure");
    start(40, 0, 1'b1, 1'b0, 1'b0);
    finish_capture("gapped");
    start(40, 0, 1'b0, 1'b0, 1'b0);
    while (cnt != 42) cyc();
    @(negedge clk);
    chk("pre_reset_state", state, 2);
    reset = 1'b1;
    sample_valid = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    since_rst = 0;
    trig_at = 80;
    arm_now = 1'b1;
    finish_capture("rearm");
    start(40, 0, 1'b0, 1'b0, 1'b1);
    finish_capture("ignored_arm");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
